// File: rtl/fsk_byte_deframer.sv
// Async-character deframer behind the FSK bit detector: start/data/parity/stop framing
// into a small first-word-fall-through FIFO with registered error pulses.
module fsk_byte_deframer #(
  parameter int NDATA      = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_bit,
  input  logic               ok_rx_bit,
  input  logic               fsk_start,
  input  logic               fsk_res,
  output logic [NDATA-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               busy,
  output logic               frame_err,
  output logic               par_err,
  output logic               abort,
  output logic               ovf
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  state_e           state_q, state_d;
  logic [NDATA-1:0] shreg_q, shreg_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic             acc_q, acc_d;
  logic             bad_q, bad_d;
  logic             push_req;
  logic             ferr_d, perr_d, abort_d;
  logic             frame_err_q, par_err_q, abort_q, ovf_q;

  logic [NDATA-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0] cnt_q;
  logic             full, pop, do_push, ovf_d;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    acc_d    = acc_q;
    bad_d    = bad_q;
    push_req = 1'b0;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
    abort_d  = 1'b0;
    if (fsk_res) begin
      state_d = IDLE;
      shreg_d = '0;
      bcnt_d  = '0;
      acc_d   = 1'b0;
      bad_d   = 1'b0;
      abort_d = (state_q == DATA) || (state_q == PAR) || (state_q == STOP);
    end else if (fsk_start) begin
      state_d = START;
      shreg_d = '0;
      bcnt_d  = '0;
      acc_d   = 1'b0;
      bad_d   = 1'b0;
    end else if (ok_rx_bit) begin
      case (state_q)
        IDLE: ;
        START: begin
          shreg_d = '0;
          bcnt_d  = '0;
          acc_d   = 1'b0;
          bad_d   = 1'b0;
          if (rx_bit) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          // LSB arrives first, so shift right and insert at the MSB
          shreg_d = (shreg_q >> 1) | (NDATA'(rx_bit) << (NDATA-1));
          acc_d   = acc_q ^ rx_bit;
          bcnt_d  = bcnt_q + 4'd1;
          if (bcnt_q == 4'(NDATA-1))
            state_d = (PARITY_EN != 0) ? PAR : STOP;
        end
        PAR: begin
          if ((acc_q ^ rx_bit) != 1'(PARITY_ODD)) bad_d = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          push_req = rx_bit & ~bad_q;
          ferr_d   = ~rx_bit;
          perr_d   = bad_q;
          state_d  = START;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign full    = (cnt_q == (FIFO_AW+1)'(DEPTH));
  assign pop     = (cnt_q != '0) & dout_ready;
  assign do_push = push_req & (~full | pop);
  assign ovf_d   = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bcnt_q      <= '0;
      acc_q       <= 1'b0;
      bad_q       <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      ovf_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bcnt_q      <= bcnt_d;
      acc_q       <= acc_d;
      bad_q       <= bad_d;
      frame_err_q <= ferr_d;
      par_err_q   <= perr_d;
      abort_q     <= abort_d;
      ovf_q       <= ovf_d;
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= shreg_q;
  end

  // Storage is not reset, so the head is masked while empty
  assign dout       = (cnt_q != '0) ? mem_q[rptr_q] : '0;
  assign dout_valid = (cnt_q != '0);
  assign fifo_cnt   = cnt_q;
  assign busy       = (state_q != IDLE);
  assign frame_err  = frame_err_q;
  assign par_err    = par_err_q;
  assign abort      = abort_q;
  assign ovf        = ovf_q;

endmodule
